// File: rtl/ang_spi_master.sv
// ang_spi_master: single-beat register slave that runs 1..16 bit SPI
// transfers to the external angle ADC. Control fields are copied at the
// start of a transfer so the bus can reprogram CTRL while a transfer runs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no transfer; csn follows ASS/SS, sclk low
//   S_SETUP | csn asserted, first MOSI bit presented, one half-period
//   S_SHIFT | sclk toggles at the end of each half-period, 2*LEN edges
//   S_HOLD  | sclk low for one half-period before csn is released
module ang_spi_master #(
  parameter logic [1:0] OFFSET_SPI_CTRL   = 2'b00,
  parameter logic [1:0] OFFSET_SPI_DATA   = 2'b01,
  parameter logic [1:0] OFFSET_SPI_STATUS = 2'b10
) (
  input  logic        clk64_i,
  input  logic        rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_irq_o,
  output logic        spi_sclk_o,
  output logic        spi_csn_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] ctrl;
  logic [15:0] rx_data;
  logic        irq_flag, ovr, ack;
  logic [15:0] dat_q;

  // per-transfer copies of the CTRL fields
  logic        sh_lsb, sh_ass, sh_tx_neg, sh_rx_neg;
  logic [3:0]  sh_div;
  logic [4:0]  sh_len;

  logic [3:0]  hp_cnt;
  logic [5:0]  edges_left;
  logic [15:0] tx_sr, rx_sr;
  logic        sclk;

  logic        acc, wr_ctrl, wr_data, rd_data, rd_status;
  logic        busy, start, hp_end, last_edge, done;
  logic        rising, first_edge, rx_evt, tx_evt, ass_eff;
  logic [4:0]  len_cfg;

  // The ack cycle is blind to a new strobe, so a held strobe is one access.
  assign acc       = wb_cyc_i & wb_stb_i & ~ack;
  assign wr_ctrl   = acc &  wb_we_i & (wb_adr_i == OFFSET_SPI_CTRL);
  assign wr_data   = acc &  wb_we_i & (wb_adr_i == OFFSET_SPI_DATA);
  assign rd_data   = acc & ~wb_we_i & (wb_adr_i == OFFSET_SPI_DATA);
  assign rd_status = acc & ~wb_we_i & (wb_adr_i == OFFSET_SPI_STATUS);

  assign busy       = (state != S_IDLE);
  assign start      = wr_data & ~busy;
  assign hp_end     = (hp_cnt == 4'd0);
  assign last_edge  = (edges_left == 6'd1);
  assign done       = (state == S_HOLD) & hp_end;
  assign len_cfg    = (ctrl[3:0] == 4'd0) ? 5'd16 : {1'b0, ctrl[3:0]};

  // Odd edges rise. With TX on the rising edge the first rising edge is
  // skipped so the bit presented in SETUP is held until it has been sampled.
  assign rising     = ~sclk;
  assign first_edge = (edges_left == {sh_len, 1'b0});
  assign rx_evt     = rising ^ sh_rx_neg;
  assign tx_evt     = sh_tx_neg ? ~rising : (rising & ~first_edge);

  assign ass_eff    = busy ? sh_ass : ctrl[12];
  assign spi_csn_o  = ass_eff ? ~busy : ~ctrl[9];
  assign spi_sclk_o = sclk;
  assign spi_mosi_o = busy & (sh_lsb ? tx_sr[0] : tx_sr[15]);
  assign wb_ack_o   = ack;
  assign wb_dat_o   = dat_q;
  assign wb_irq_o   = irq_flag & ctrl[14];

  // state register
  always_ff @(posedge clk64_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: if (hp_end) state_nxt = S_SHIFT;
      S_SHIFT: if (hp_end && last_edge) state_nxt = S_HOLD;
      S_HOLD:  if (hp_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bus side: ack, read mux, CTRL register, irq and overrun flags
  always_ff @(posedge clk64_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack      <= 1'b0;
      dat_q    <= '0;
      ctrl     <= '0;
      irq_flag <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      ack   <= acc;
      dat_q <= '0;
      if (acc && !wb_we_i) begin
        if (wb_adr_i == OFFSET_SPI_CTRL)        dat_q <= ctrl;
        else if (wb_adr_i == OFFSET_SPI_DATA)   dat_q <= rx_data;
        else if (wb_adr_i == OFFSET_SPI_STATUS) dat_q <= {13'd0, ovr, irq_flag, busy};
      end
      if (wr_ctrl) ctrl <= wb_dat_i & 16'h7EFF;
      if (done)                                        irq_flag <= 1'b1;
      else if (rd_data || (wr_ctrl && !wb_dat_i[14]))  irq_flag <= 1'b0;
      if (wr_data && busy) ovr <= 1'b1;
      else if (rd_status)  ovr <= 1'b0;
    end
  end

  // serial datapath: shadow load, half-period timer, sclk and shift registers
  always_ff @(posedge clk64_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sh_lsb     <= 1'b0;
      sh_ass     <= 1'b0;
      sh_tx_neg  <= 1'b0;
      sh_rx_neg  <= 1'b0;
      sh_div     <= '0;
      sh_len     <= '0;
      hp_cnt     <= '0;
      edges_left <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      sclk       <= 1'b0;
      rx_data    <= '0;
    end else if (start) begin
      sh_lsb     <= ctrl[13];
      sh_ass     <= ctrl[12];
      sh_tx_neg  <= ctrl[11];
      sh_rx_neg  <= ctrl[10];
      sh_div     <= ctrl[7:4];
      sh_len     <= len_cfg;
      hp_cnt     <= ctrl[7:4];
      edges_left <= {len_cfg, 1'b0};
      tx_sr      <= ctrl[13] ? wb_dat_i : (wb_dat_i << (5'd16 - len_cfg));
      rx_sr      <= '0;
      sclk       <= 1'b0;
    end else if (busy) begin
      hp_cnt <= hp_end ? sh_div : hp_cnt - 4'd1;
      if (state == S_SHIFT && hp_end) begin
        sclk       <= ~sclk;
        edges_left <= edges_left - 6'd1;
        if (rx_evt) rx_sr <= sh_lsb ? {spi_miso_i, rx_sr[15:1]} : {rx_sr[14:0], spi_miso_i};
        if (tx_evt) tx_sr <= sh_lsb ? (tx_sr >> 1) : (tx_sr << 1);
      end
      if (done) rx_data <= sh_lsb ? (rx_sr >> (5'd16 - sh_len)) : rx_sr;
    end
  end

endmodule

// File: tb/tb_ang_spi_master.sv
// Directed bench for ang_spi_master: bus accesses push their expected ack
// cycle and read data into a queue, a monitor pops on every ack.
module tb_ang_spi_master;

  logic        clk64 = 1'b0;
  logic        rstn  = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [1:0]  wb_adr = 2'b00;
  logic [15:0] wb_dat_i = 16'h0000;
  logic [15:0] wb_dat_o;
  logic        wb_ack, wb_irq, sclk, csn, mosi, miso;

  logic        loop = 1'b0;
  logic [15:0] adc_word = 16'hA5C0;
  int          adc_idx = 0;
  logic        adc_bit;
  int          sclk_rises = 0;
  int          cyc_n = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int          cyc;
    logic        chk;
    logic [15:0] dat;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  ang_spi_master dut (
    .clk64_i(clk64), .rstn_i(rstn),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack), .wb_irq_o(wb_irq),
    .spi_sclk_o(sclk), .spi_csn_o(csn), .spi_mosi_o(mosi), .spi_miso_i(miso)
  );

  always #8 clk64 = ~clk64;
  always @(posedge clk64) cyc_n <= cyc_n + 1;
  always @(posedge sclk) sclk_rises <= sclk_rises + 1;

  // ADC model: MSB first, next bit on each falling sclk, restart on csn high
  always @(negedge sclk or posedge csn) begin
    if (csn) adc_idx <= 0;
    else     adc_idx <= adc_idx + 1;
  end
  always_comb adc_bit = (adc_idx < 16) ? adc_word[15 - adc_idx] : 1'b0;
  assign miso = loop ? mosi : adc_bit;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every ack must match the oldest outstanding access
  always @(negedge clk64) begin
    if (wb_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: ack at cycle %0d with no access pending", cyc_n);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_ack_cycle"}, cyc_n, e.cyc);
        if (e.chk) check({e.name, "_rdata"}, int'(wb_dat_o), int'(e.dat));
      end
    end
  end

  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [15:0] d,
                           input logic chk, input logic [15:0] exp, input string name,
                           input int hold = 1);
    exp_t e;
    @(negedge clk64);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = d;
    e.cyc = cyc_n + 1; e.chk = chk; e.dat = exp; e.name = name;
    sb_q.push_back(e);
    repeat (hold) @(negedge clk64);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [15:0] d, input string name);
    wb_access(1'b1, adr, d, 1'b0, 16'h0000, name);
  endtask

  task automatic rd(input logic [1:0] adr, input logic [15:0] exp, input string name);
    wb_access(1'b0, adr, 16'h0000, 1'b1, exp, name);
  endtask

  // waits until csn releases; length counted from the ack cycle of the DATA write
  task automatic wait_done(input int t0, input int exp_len, input string name);
    int n = 0;
    while (csn === 1'b0 && n < 2000) begin
      @(negedge clk64);
      n++;
    end
    if (csn !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: csn still low after %0d cycles", name, n);
    end else begin
      check({name, "_len"}, cyc_n - t0, exp_len);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, r0;
    repeat (3) @(negedge clk64);
    rstn = 1'b1;
    @(negedge clk64);

    // reset values
    check("rst_ack", wb_ack, 0);
    check("rst_irq", wb_irq, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sclk", sclk, 0);
    check("rst_csn", csn, 1);
    check("rst_mosi", mosi, 0);
    rd(2'b10, 16'h0000, "rst_status");
    wb_access(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0000, "held_stb_status", 2);
    wr(2'b00, 16'hFFFF, "ctrl_all_ones");
    rd(2'b00, 16'h7EFF, "ctrl_reserved_bits");
    wr(2'b00, 16'h0200, "ctrl_manual_ss");
    check("manual_ss_csn", csn, 0);
    wr(2'b00, 16'h0000, "ctrl_clear");
    check("manual_ss_off_csn", csn, 1);
    wr(2'b11, 16'h1234, "reserved_wr");
    rd(2'b11, 16'h0000, "reserved_rd");

    // 12-bit ADC read, DIV=4
    loop = 1'b0;
    wr(2'b00, 16'h584C, "adc_ctrl");
    r0 = sclk_rises;
    wr(2'b01, 16'h0000, "adc_start");
    t0 = cyc_n;
    check("adc_csn_in_ack", csn, 0);
    wait_done(t0, 130, "adc");
    check("adc_rises", sclk_rises - r0, 12);
    check("adc_irq_set", wb_irq, 1);
    rd(2'b10, 16'h0002, "adc_status_irq");
    rd(2'b01, 16'h0A5C, "adc_data");
    check("adc_irq_cleared", wb_irq, 0);

    // loopback, 16 bits, LSB first, DIV=0
    loop = 1'b1;
    wr(2'b00, 16'h7800, "lb16_ctrl");
    r0 = sclk_rises;
    wr(2'b01, 16'h8001, "lb16_start");
    t0 = cyc_n;
    wait_done(t0, 34, "lb16");
    check("lb16_rises", sclk_rises - r0, 16);
    rd(2'b01, 16'h8001, "lb16_data");

    // loopback, 8 bits, LSB first: bit 0 must be on MOSI first
    wr(2'b00, 16'h7808, "lb8_ctrl");
    wr(2'b01, 16'h0035, "lb8_start");
    t0 = cyc_n;
    check("lb8_first_bit", mosi, 1);
    wait_done(t0, 18, "lb8");
    rd(2'b01, 16'h0035, "lb8_data");

    // overrun and CTRL shadowing: MSB first, LEN=4, DIV=2
    wr(2'b00, 16'h5824, "ovr_ctrl");
    wr(2'b01, 16'h000A, "ovr_start");
    t0 = cyc_n;
    check("ovr_first_bit", mosi, 1);
    wr(2'b01, 16'h0005, "ovr_second_write");
    rd(2'b10, 16'h0005, "ovr_status");
    rd(2'b10, 16'h0001, "ovr_status_cleared");
    wr(2'b00, 16'h5814, "ovr_ctrl_div1");
    wait_done(t0, 30, "ovr_xfer");
    rd(2'b01, 16'h000A, "ovr_data");
    rd(2'b00, 16'h5814, "ovr_ctrl_readback");
    wr(2'b01, 16'h0003, "div1_start");
    t0 = cyc_n;
    wait_done(t0, 20, "div1_xfer");
    rd(2'b01, 16'h0003, "div1_data");

    // IE=0: flag sets, irq output stays low
    wr(2'b00, 16'h1804, "noie_ctrl");
    wr(2'b01, 16'h0006, "noie_start");
    t0 = cyc_n;
    wait_done(t0, 10, "noie");
    check("noie_irq_low", wb_irq, 0);
    rd(2'b10, 16'h0002, "noie_status");
    rd(2'b01, 16'h0006, "noie_data");
    rd(2'b10, 16'h0000, "noie_status_clear");

    // DATA read captured on the completion edge: set wins
    wr(2'b00, 16'h5804, "race_ctrl");
    wr(2'b01, 16'h0009, "race_start");
    repeat (8) @(negedge clk64);
    wb_access(1'b0, 2'b01, 16'h0000, 1'b0, 16'h0000, "race_read");
    check("race_csn_high", csn, 1);
    check("race_irq_kept", wb_irq, 1);
    rd(2'b01, 16'h0009, "race_data");
    check("race_irq_cleared", wb_irq, 0);

    // reset mid-transfer
    wr(2'b00, 16'h5824, "mid_ctrl");
    wr(2'b01, 16'h000F, "mid_start");
    repeat (8) @(negedge clk64);
    check("mid_busy_csn", csn, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_csn", csn, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_irq", wb_irq, 0);
    @(negedge clk64);
    rstn = 1'b1;
    rd(2'b00, 16'h0000, "mid_ctrl_reset");
    wr(2'b00, 16'h5804, "post_ctrl");
    wr(2'b01, 16'h000C, "post_start");
    t0 = cyc_n;
    wait_done(t0, 10, "post");
    check("post_irq", wb_irq, 1);
    rd(2'b01, 16'h000C, "post_data");

    repeat (4) @(negedge clk64);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_ack: %0d accesses never acked", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ang_spi_master.md
# ang_spi_master

Wishbone-style 16-bit SPI master that sits directly downstream of the angle/ADC SPI controller. It accepts single-beat register transactions on a 2-bit offset bus and runs the serial transfer to the external angle ADC. It returns read data and a single-cycle `ack`, and raises a level `irq` when a transfer completes. The controller's `spi_*_o` outputs connect to this block's `wb_*_i` inputs, and `wb_ack_o` / `wb_irq_o` drive the controller's `spi_ack_i` / `spi_irq_i`.

## Interface
Parameters:
- `OFFSET_SPI_CTRL`, default 2'b00, offset of the control register.
- `OFFSET_SPI_DATA`, default 2'b01, offset of the TX/RX data register. A write to it starts a transfer.
- `OFFSET_SPI_STATUS`, default 2'b10, offset of the read-only status register.

Ports:
- `clk64_i`  in  1  64 MHz system clock; the only clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe. A 1-cycle pulse is legal.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  2  register offset.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data, valid while `wb_ack_o`=1.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `wb_irq_o`  out  1  transfer-complete interrupt (level).
- `spi_sclk_o`  out  1  serial clock, idles low.
- `spi_csn_o`  out  1  ADC chip select, active low.
- `spi_mosi_o`  out  1  serial data out.
- `spi_miso_i`  in  1  serial data in. Already synchronous to the sclk domain; no extra synchroniser is required.

## Operation
CTRL register (R/W, reset 16'h0000):
- [14] IE: interrupt enable.
- [13] LSB: 1 = LSB first.
- [12] ASS: automatic chip select.
- [11] TX_NEG: MOSI changes on the falling sclk edge.
- [10] RX_NEG: MISO is sampled on the falling sclk edge.
- [9] SS: manual chip select when ASS=0.
- [7:4] DIV: sclk half-period = DIV+1 clocks.
- [3:0] LEN: bit count; 0 means 16.
- [15] and [8] are reserved: they read back 0.
- Example: 16'h584C gives IE, ASS and TX_NEG set, rising-edge sampling, DIV=4 (6.4 MHz sclk) and a 12-bit transfer.

DATA register:
- A write loads the shift register and starts a transfer.
- A read returns the last received word, right-aligned, with bits above LEN zeroed.
- A DATA read clears the irq.

STATUS register (RO):
- [0] BUSY.
- [1] IRQ pending (the raw flag, before the IE mask).
- [2] OVR: a DATA write arrived while BUSY.
- Reading STATUS clears OVR.

Transfer setup:
- CTRL fields are shadowed at transfer start. A CTRL write during BUSY is accepted and takes effect on the next transfer.
- A DATA write while BUSY is acked, otherwise ignored, and sets OVR.

Transfer FSM:
- IDLE → SETUP on a DATA write. `spi_csn_o`=0 if ASS=1, otherwise `spi_csn_o`=~SS at all times. The first MOSI bit is presented.
- SETUP → SHIFT after 1 half-period.
- SHIFT produces 2·LEN half-periods; sclk toggles at the end of each half-period.
- MOSI updates on the edge selected by TX_NEG; MISO is sampled on the edge selected by RX_NEG.
- SHIFT → HOLD after the last edge; HOLD lasts 1 half-period with sclk low.
- HOLD → IDLE: csn goes high, BUSY clears, the irq flag sets and the RX word is latched into DATA.

Interrupt:
- `wb_irq_o` = IRQ flag & IE.
- The flag clears on a DATA read, or on a CTRL write with IE=0.
- If a set and a DATA read occur in the same cycle, the set wins.

## Timing
- Reset values: `wb_ack_o`=0, `wb_irq_o`=0, `wb_dat_o`=0, `spi_sclk_o`=0, `spi_csn_o`=1, `spi_mosi_o`=0. All registers are 0 and the FSM is in IDLE.
- Reset asserted mid-transfer aborts immediately with the same values.
- Bus handshake:
  - A cycle with `wb_cyc_i`&`wb_stb_i`=1 is captured.
  - `wb_ack_o`=1 exactly one clock later, for exactly one clock.
  - Read data is valid in the ack cycle.
  - A new strobe during the ack cycle is ignored.
  - Every captured access is acked, including accesses to reserved offset 2'b11, which read 0 and ignore writes.
- BUSY and `spi_csn_o`=0 (with ASS=1) appear in the ack cycle of the DATA write.
- Transfer length from SETUP entry to IDLE is (2·LEN+2)·(DIV+1) clocks. For 16'h584C this is 130 clocks (2.03 µs).
- The irq flag is visible on `wb_irq_o` in the first IDLE cycle.
- Combinational paths from wb inputs to any output are forbidden.

## Test plan
- **Reset values:** reset → all outputs hold the stated reset values. A STATUS read returns 16'h0000 with ack one cycle after the strobe.
- **12-bit ADC read:** write CTRL=16'h584C, write DATA=0, MISO model returns 12'hA5C.
  - `spi_csn_o` low for 130 clocks with 12 rising edges.
  - `wb_irq_o`=1 afterwards.
  - DATA read returns 16'h0A5C and `wb_irq_o` drops the next cycle.
- **Loopback, full width, LSB first:** LEN=0, DIV=0, LSB=1, MOSI looped to MISO, write DATA=16'h8001 → 34 clocks, 16 sclk pulses, DATA reads 16'h8001, bit 0 shifted first.
- **Overrun and CTRL shadowing:** a DATA write during BUSY → acked, transfer unaffected, STATUS=16'h0005. A following STATUS read returns OVR=0. A CTRL write with DIV=1 during BUSY → current transfer keeps its DIV; the next transfer uses a 2-clock half-period.
- **Interrupt edge cases:** IE=0 → flag sets (STATUS[1]=1) but `wb_irq_o` stays 0. A DATA read in the same cycle as completion → irq remains 1.
- **Reset mid-transfer:** `rstn_i` low during SHIFT → `spi_csn_o`=1 and `spi_sclk_o`=0 immediately. After release, CTRL=0, and a fresh transfer completes normally.
